// File: rtl/vit_pkg.sv
// Shared types and helpers for the 4-state (K=3) Viterbi survivor-path stage.
package vit_pkg;

    localparam int K          = 3;
    localparam int NUM_STATES = 1 << (K - 1);

    typedef logic [1:0] state_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } surv_state_t;

    // The low bit of s' was the high bit of its predecessor; the decision supplies the rest.
    function automatic state_t pred(input state_t s_next, input logic d);
        return {s_next[0], d};
    endfunction

endpackage

// File: rtl/vit_surv_cell.sv
// One state's register-exchange survivor path: picks a predecessor path and appends this
// state's input bit. The path MSB holds the oldest bit.
module vit_surv_cell
    import vit_pkg::*;
#(
    parameter int     DEPTH = 15,
    parameter state_t STATE = 2'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_dec,
    input  logic [DEPTH-1:0] i_pred0,
    input  logic [DEPTH-1:0] i_pred1,
    output logic [DEPTH-1:0] o_path,
    output logic [DEPTH-1:0] o_next
);

    logic [DEPTH-1:0] r_path;
    logic [DEPTH-1:0] w_sel;

    assign w_sel  = i_dec ? i_pred1 : i_pred0;
    assign o_next = {w_sel[DEPTH-2:0], STATE[1]};
    assign o_path = r_path;

    // Survivor path register
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_path <= '0;
        end else if (i_en) begin
            r_path <= o_next;
        end else begin
            r_path <= r_path;
        end
    end

endmodule

// File: rtl/viterbi_survivor_unit.sv
// Viterbi survivor-path unit: register exchange over 4 states, emission after DEPTH symbols,
// frame-end flush of the best path. Optional macro VIT_SURV_OUT_REG_EN adds an output stage.
module viterbi_survivor_unit
    import vit_pkg::*;
#(
    parameter int DEPTH = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_dec,
    input  logic [1:0] in_best,
    input  logic       in_last,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_last
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);

    surv_state_t      r_state, w_state_nxt;
    logic [CW-1:0]    r_count, w_count_nxt, w_count_inc;
    logic [CW-1:0]    r_remain, w_remain_nxt, w_remain_last;
    logic [DEPTH-1:0] r_flush, w_flush_nxt;
    logic [DEPTH-1:0] w_path [NUM_STATES];
    logic [DEPTH-1:0] w_next [NUM_STATES];
    logic [DEPTH-1:0] w_best_next;
    logic             r_in_ready;
    logic             w_accept, w_emit, w_clr;
    logic             r_out_valid, r_out_bit, r_out_last;
    logic             w_ov_nxt, w_ob_nxt, w_ol_nxt;

    for (genvar g = 0; g < NUM_STATES; g++) begin : g_cell
        localparam state_t SN = state_t'(g);
        vit_surv_cell #(
            .DEPTH (DEPTH),
            .STATE (SN)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .i_clr   (w_clr),
            .i_en    (w_accept),
            .i_dec   (in_dec[g]),
            .i_pred0 (w_path[pred(SN, 1'b0)]),
            .i_pred1 (w_path[pred(SN, 1'b1)]),
            .o_path  (w_path[g]),
            .o_next  (w_next[g])
        );
    end

    assign w_accept      = in_valid & r_in_ready;
    assign w_count_inc   = (r_count == C_DEPTH) ? C_DEPTH : r_count + CW'(1);
    assign w_emit        = w_accept & (w_count_inc == C_DEPTH);
    assign w_best_next   = w_next[in_best];
    // A full path already gave up its oldest bit through the normal emission.
    assign w_remain_last = (w_count_inc == C_DEPTH) ? (C_DEPTH - CW'(1)) : w_count_inc;

    // Next-state, fill count, flush bookkeeping and output bit selection
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_remain_nxt = r_remain;
        w_flush_nxt  = r_flush;
        w_clr        = 1'b0;
        w_ov_nxt     = 1'b0;
        w_ob_nxt     = 1'b0;
        w_ol_nxt     = 1'b0;
        case (r_state)
            FILL, RUN: begin
                if (w_accept) begin
                    w_count_nxt = w_count_inc;
                    if (w_emit) begin
                        w_ov_nxt = 1'b1;
                        w_ob_nxt = w_best_next[DEPTH-1];
                    end else begin
                        w_ov_nxt = 1'b0;
                    end
                    if (in_last) begin
                        w_state_nxt  = FLUSH;
                        w_remain_nxt = w_remain_last;
                        w_flush_nxt  = w_best_next << (C_DEPTH - w_remain_last);
                    end else if (w_emit) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            FLUSH: begin
                w_ov_nxt     = 1'b1;
                w_ob_nxt     = r_flush[DEPTH-1];
                w_flush_nxt  = r_flush << 1;
                w_remain_nxt = r_remain - CW'(1);
                if (r_remain == CW'(1)) begin
                    w_ol_nxt    = 1'b1;
                    w_state_nxt = FILL;
                    w_count_nxt = '0;
                    w_clr       = 1'b1;
                end else begin
                    w_ol_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    // Control state and primary output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_count     <= '0;
            r_remain    <= '0;
            r_flush     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_remain    <= w_remain_nxt;
            r_flush     <= w_flush_nxt;
            r_in_ready  <= (w_state_nxt != FLUSH);
            r_out_valid <= w_ov_nxt;
            r_out_bit   <= w_ob_nxt;
            r_out_last  <= w_ol_nxt;
        end
    end

    assign in_ready = r_in_ready;

`ifdef VIT_SURV_OUT_REG_EN
    logic r_out_valid_d, r_out_bit_d, r_out_last_d;

    // Extra output retiming stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid_d <= 1'b0;
            r_out_bit_d   <= 1'b0;
            r_out_last_d  <= 1'b0;
        end else begin
            r_out_valid_d <= r_out_valid;
            r_out_bit_d   <= r_out_bit;
            r_out_last_d  <= r_out_last;
        end
    end

    assign out_valid = r_out_valid_d;
    assign out_bit   = r_out_bit_d;
    assign out_last  = r_out_last_d;
`else
    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;
    assign out_last  = r_out_last;
`endif

endmodule

// File: tb/tb_viterbi_survivor_unit.sv
// Self-checking bench for viterbi_survivor_unit against a queue/array path model.
module tb_viterbi_survivor_unit;

    localparam int DEPTH = 15;
`ifdef VIT_SURV_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic b;
        logic l;
        int   e;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_dec;
    logic [1:0] in_best;
    logic       in_last;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;

    int  total = 0;
    int  bad   = 0;
    int  edge_cnt = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t mon_ev;
    bit  mpath [4][DEPTH];
    int  mlen = 0;
    bit  pat [8];
    bit  spat [5];

    viterbi_survivor_unit #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dec    (in_dec),
        .in_best   (in_best),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            mon_ev.b = out_bit;
            mon_ev.l = out_last;
            mon_ev.e = edge_cnt;
            obs_q.push_back(mon_ev);
        end
    end

    // Reference: every state's path is its predecessor's path plus the state's high bit,
    // keeping at most DEPTH bits, oldest at index 0.
    task automatic model_accept(input logic [3:0] d, input logic [1:0] b, input logic l, input int acc);
        bit  nxt [4][DEPTH];
        int  nlen;
        int  start;
        int  p;
        ev_t ev;
        nlen = (mlen < DEPTH) ? mlen + 1 : DEPTH;
        for (int s = 0; s < 4; s++) begin
            p = (s % 2) * 2 + int'(d[s]);
            for (int i = 0; i < nlen - 1; i++) nxt[s][i] = mpath[p][i + mlen + 1 - nlen];
            nxt[s][nlen-1] = (s >= 2);
        end
        mpath = nxt;
        mlen  = nlen;
        start = 0;
        if (mlen == DEPTH) begin
            ev.b = mpath[b][0]; ev.l = 1'b0; ev.e = acc + LAT - 1;
            exp_q.push_back(ev);
            start = 1;
        end
        if (l) begin
            for (int i = start; i < mlen; i++) begin
                ev.b = mpath[b][i]; ev.l = (i == mlen - 1); ev.e = acc + LAT + i - start;
                exp_q.push_back(ev);
            end
            mlen = 0;
        end
    endtask

    task automatic send(input logic [3:0] d, input logic [1:0] b, input logic l);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_dec = d; in_best = b; in_last = l;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++; bad++;
            $display("FAIL send_timeout actual in_ready=%0b required 1", in_ready);
        end else begin
            model_accept(d, b, l, edge_cnt + 1);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Encoder-consistent decisions: the true next state points back at the true state.
    task automatic enc_send(input int n, input bit use_short, input bit last_end);
        logic [1:0] s, sn;
        logic [3:0] d;
        bit         u;
        s = 2'd0;
        for (int t = 0; t < n; t++) begin
            u  = use_short ? spat[t % 5] : pat[t % 8];
            sn = {u, s[1]};
            d  = 4'($urandom);
            d[sn] = s[0];
            send(d, sn, last_end && (t == n - 1));
            s = sn;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mlen = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic settle();
        repeat (2 * DEPTH + 10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid actual=%0b required=0", out_valid); end
        total++; if (out_bit !== 1'b0)   begin bad++; $display("FAIL reset_out_bit actual=%0b required=0", out_bit); end
        total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last actual=%0b required=0", out_last); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL reset_in_ready actual=%0b required=0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL ready_after_reset actual=%0b required=1", in_ready); end
    endtask

    task automatic test_zero_fill();
        do_reset();
        for (int t = 0; t < 20; t++) send(4'b0000, 2'd0, 1'b0);
        idle();
        settle();
        total++; if (obs_q.size() != 6) begin bad++; $display("FAIL zero_fill_count actual=%0d required=6", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL zero_fill_bit%0d actual b=%0b l=%0b e=%0d required b=%0b l=%0b e=%0d",
                         i, obs_q[i].b, obs_q[i].l, obs_q[i].e, exp_q[i].b, exp_q[i].l, exp_q[i].e);
            end
        end
    endtask

    task automatic test_encoder_run();
        do_reset();
        enc_send(30, 1'b0, 1'b0);
        idle();
        settle();
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL enc_run_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL enc_run_bit%0d actual b=%0b l=%0b e=%0d required b=%0b l=%0b e=%0d",
                         i, obs_q[i].b, obs_q[i].l, obs_q[i].e, exp_q[i].b, exp_q[i].l, exp_q[i].e);
            end
        end
        for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i].b !== pat[i % 8]) begin bad++; $display("FAIL enc_run_u%0d actual=%0b required=%0b", i, obs_q[i].b, pat[i % 8]); end
        end
    endtask

    task automatic test_encoder_flush();
        int low;
        do_reset();
        enc_send(30, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        low = (in_ready === 1'b0) ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready === 1'b0) low++;
        end
        total++; if (low != DEPTH - 1) begin bad++; $display("FAIL flush_ready_low actual=%0d required=%0d", low, DEPTH - 1); end
        total++; if (obs_q.size() != 30) begin bad++; $display("FAIL flush_count actual=%0d required=30", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL flush_bit%0d actual b=%0b l=%0b e=%0d required b=%0b l=%0b e=%0d",
                         i, obs_q[i].b, obs_q[i].l, obs_q[i].e, exp_q[i].b, exp_q[i].l, exp_q[i].e);
            end
        end
        for (int i = 0; i < 30 && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i].b !== pat[i % 8] || obs_q[i].l !== (i == 29)) begin
                bad++;
                $display("FAIL flush_u%0d actual b=%0b l=%0b required b=%0b l=%0b", i, obs_q[i].b, obs_q[i].l, pat[i % 8], (i == 29));
            end
        end
    endtask

    task automatic test_short_frame();
        do_reset();
        enc_send(5, 1'b1, 1'b1);
        idle();
        settle();
        total++; if (obs_q.size() != 5) begin bad++; $display("FAIL short_count actual=%0d required=5", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].b !== spat[i]) begin
                bad++;
                $display("FAIL short_bit%0d actual b=%0b l=%0b e=%0d required b=%0b l=%0b e=%0d",
                         i, obs_q[i].b, obs_q[i].l, obs_q[i].e, exp_q[i].b, exp_q[i].l, exp_q[i].e);
            end
        end
    endtask

    task automatic test_flush_ignore();
        do_reset();
        enc_send(5, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready === 1'b0) begin
                in_valid = 1'b1; in_dec = 4'($urandom); in_best = 2'($urandom); in_last = 1'($urandom);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
        end
        settle();
        total++; if (obs_q.size() != 5) begin bad++; $display("FAIL ignore_count actual=%0d required=5", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].b !== spat[i]) begin
                bad++;
                $display("FAIL ignore_bit%0d actual b=%0b l=%0b e=%0d required b=%0b l=%0b e=%0d",
                         i, obs_q[i].b, obs_q[i].l, obs_q[i].e, exp_q[i].b, exp_q[i].l, exp_q[i].e);
            end
        end
    endtask

    task automatic test_rst_in_flush();
        int seen;
        do_reset();
        enc_send(5, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rst_flush_valid actual=%0d required=0", seen); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_flush_ready actual=%0b required=0", in_ready); end
        rst = 1'b0;
        mlen = 0;
        exp_q.delete();
        obs_q.delete();
        for (int t = 0; t < 15; t++) send(4'b0000, 2'd0, t == 14);
        idle();
        settle();
        total++; if (obs_q.size() != 15) begin bad++; $display("FAIL rst_refill_count actual=%0d required=15", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].b !== 1'b0) begin
                bad++;
                $display("FAIL rst_refill_bit%0d actual b=%0b l=%0b e=%0d required b=%0b l=%0b e=%0d",
                         i, obs_q[i].b, obs_q[i].l, obs_q[i].e, exp_q[i].b, exp_q[i].l, exp_q[i].e);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_dec = 4'd0; in_best = 2'd0; in_last = 1'b0;
        pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        spat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        test_reset();
        test_zero_fill();
        test_encoder_run();
        test_encoder_flush();
        test_short_frame();
        test_flush_ignore();
        test_rst_in_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
